// File: rtl/pulpino_gpio_link.sv
// Word <-> byte bridge between the host register file and the PULPino GPIO bank, with mod-4 turn-token handshakes.
// Optional PULPINO_GPIO_SYNC_EN puts 2-flop synchronizers on the PULPino-driven inputs.
module pulpino_gpio_link (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] read_data,
  input  logic        do_read,
  output logic [7:0]  gpio_data_in,
  output logic [1:0]  data_in_io_turn,
  input  logic [1:0]  data_in_pulpino_turn,
  output logic        data_in_done,
  input  logic [7:0]  gpio_data_out,
  input  logic [1:0]  data_out_pulpino_turn,
  output logic [1:0]  data_out_io_turn,
  output logic [31:0] write_data,
  output logic        data_out_done
);

  logic [1:0] in_pturn;
  logic [1:0] out_pturn;
  logic [7:0] out_byte;

`ifdef PULPINO_GPIO_SYNC_EN
  logic [1:0] in_pturn_s1, out_pturn_s1;
  logic [7:0] out_byte_s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_pturn_s1  <= '0;
      in_pturn     <= '0;
      out_pturn_s1 <= '0;
      out_pturn    <= '0;
      out_byte_s1  <= '0;
      out_byte     <= '0;
    end else begin
      in_pturn_s1  <= data_in_pulpino_turn;
      in_pturn     <= in_pturn_s1;
      out_pturn_s1 <= data_out_pulpino_turn;
      out_pturn    <= out_pturn_s1;
      out_byte_s1  <= gpio_data_out;
      out_byte     <= out_byte_s1;
    end
  end
`else
  assign in_pturn  = data_in_pulpino_turn;
  assign out_pturn = data_out_pulpino_turn;
  assign out_byte  = gpio_data_out;
`endif

  // Host -> PULPino: byte k is presented with token (k+1) mod 4
  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [3:0][7:0] shadow_q, shadow_d;
  logic [7:0]      byte_d;
  logic [1:0]      turn_d;
  logic            done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      shadow_q        <= '0;
      gpio_data_in    <= '0;
      data_in_io_turn <= '0;
      data_in_done    <= 1'b0;
    end else begin
      state_q         <= state_d;
      shadow_q        <= shadow_d;
      gpio_data_in    <= byte_d;
      data_in_io_turn <= turn_d;
      data_in_done    <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    byte_d   = gpio_data_in;
    turn_d   = data_in_io_turn;
    done_d   = data_in_done;
    case (state_q)
      IDLE: if (do_read) begin
        shadow_d = read_data;
        byte_d   = read_data[7:0];
        turn_d   = 2'd1;
        done_d   = 1'b0;
        state_d  = SEND;
      end
      SEND: if (in_pturn == data_in_io_turn) begin
        // Token 00 acknowledges byte3; the last byte stays on the bus
        if (data_in_io_turn == 2'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          // Current token t acked byte t-1, so byte t goes next
          byte_d = shadow_q[data_in_io_turn];
          turn_d = data_in_io_turn + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // PULPino -> host: the ack token doubles as the byte slot index
  logic [7:0] slot0_q, slot1_q, slot2_q;
  logic       out_new;

  assign out_new = (out_pturn == data_out_io_turn + 2'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_q          <= '0;
      slot1_q          <= '0;
      slot2_q          <= '0;
      data_out_io_turn <= '0;
      write_data       <= '0;
      data_out_done    <= 1'b0;
    end else if (out_new) begin
      data_out_io_turn <= out_pturn;
      case (data_out_io_turn)
        2'd0: begin
          slot0_q       <= out_byte;
          data_out_done <= 1'b0;
        end
        2'd1: slot1_q <= out_byte;
        2'd2: slot2_q <= out_byte;
        default: begin
          write_data    <= {out_byte, slot2_q, slot1_q, slot0_q};
          data_out_done <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulpino_gpio_link.sv
// Directed bench for pulpino_gpio_link: reset, both transfer directions, busy/illegal tokens, concurrency and abort.
module tb_pulpino_gpio_link;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] read_data;
  logic        do_read;
  logic [7:0]  gpio_data_in;
  logic [1:0]  data_in_io_turn;
  logic [1:0]  data_in_pulpino_turn;
  logic        data_in_done;
  logic [7:0]  gpio_data_out;
  logic [1:0]  data_out_pulpino_turn;
  logic [1:0]  data_out_io_turn;
  logic [31:0] write_data;
  logic        data_out_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pulpino_gpio_link dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .read_data             (read_data),
    .do_read               (do_read),
    .gpio_data_in          (gpio_data_in),
    .data_in_io_turn       (data_in_io_turn),
    .data_in_pulpino_turn  (data_in_pulpino_turn),
    .data_in_done          (data_in_done),
    .gpio_data_out         (gpio_data_out),
    .data_out_pulpino_turn (data_out_pulpino_turn),
    .data_out_io_turn      (data_out_io_turn),
    .write_data            (write_data),
    .data_out_done         (data_out_done)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      read_data             = $urandom;
      do_read               = 1'($urandom);
      data_in_pulpino_turn  = 2'($urandom);
      gpio_data_out         = 8'($urandom);
      data_out_pulpino_turn = 2'($urandom);
    end
    @(negedge clk);
    n_checks++;
    if ({gpio_data_in, data_in_io_turn, data_in_done} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_in: got byte=%h turn=%b done=%b want 00/00/0", gpio_data_in, data_in_io_turn, data_in_done);
    end
    n_checks++;
    if ({write_data, data_out_io_turn, data_out_done} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_out: got word=%h turn=%b done=%b want 0/00/0", write_data, data_out_io_turn, data_out_done);
    end
    read_data = '0; do_read = 1'b0; data_in_pulpino_turn = 2'd0;
    gpio_data_out = '0; data_out_pulpino_turn = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_host_send();
    logic [7:0] eb [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [1:0] et [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    read_data = 32'hDEADBEEF; do_read = 1'b1;
    @(negedge clk);
    do_read = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (gpio_data_in !== eb[k] || data_in_io_turn !== et[k]) begin
        n_fail++;
        $display("FAIL host_byte%0d: got %h/%b want %h/%b", k, gpio_data_in, data_in_io_turn, eb[k], et[k]);
      end
      n_checks++;
      if (data_in_done !== 1'b0) begin
        n_fail++;
        $display("FAIL host_done_early%0d: got %b want 0", k, data_in_done);
      end
      @(negedge clk);
      data_in_pulpino_turn = et[k];
      @(negedge clk);
    end
    n_checks++;
    if (data_in_done !== 1'b1 || gpio_data_in !== 8'hDE || data_in_io_turn !== 2'b00) begin
      n_fail++;
      $display("FAIL host_done: got done=%b byte=%h turn=%b want 1/DE/00", data_in_done, gpio_data_in, data_in_io_turn);
    end
  endtask

  task automatic test_pulpino_send();
    logic [7:0] ob [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int k = 0; k < 4; k++) begin
      logic [1:0] tok;
      bit got;
      tok = 2'(k + 1);
      @(negedge clk);
      gpio_data_out = ob[k]; data_out_pulpino_turn = tok;
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
        @(negedge clk);
        got = (data_out_io_turn === tok);
      end
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL pulp_ack%0d: got turn=%b want %b (timeout)", k, data_out_io_turn, tok);
      end
      if (k < 3) begin
        n_checks++;
        if (write_data !== 32'h0 || data_out_done !== 1'b0) begin
          n_fail++;
          $display("FAIL pulp_partial%0d: got word=%h done=%b want 00000000/0", k, write_data, data_out_done);
        end
      end
    end
    n_checks++;
    if (write_data !== 32'h12345678 || data_out_done !== 1'b1) begin
      n_fail++;
      $display("FAIL pulp_word: got word=%h done=%b want 12345678/1", write_data, data_out_done);
    end
  endtask

  task automatic test_busy_illegal();
    logic [7:0] eb [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    read_data = 32'hCAFEF00D; do_read = 1'b1;
    @(negedge clk);
    do_read = 1'b0; read_data = 32'h0;
    @(negedge clk);
    do_read = 1'b1;
    data_in_pulpino_turn = 2'b11;
    @(negedge clk);
    do_read = 1'b0;
    n_checks++;
    if (gpio_data_in !== 8'h0D || data_in_io_turn !== 2'b01) begin
      n_fail++;
      $display("FAIL busy_hold: got %h/%b want 0D/01", gpio_data_in, data_in_io_turn);
    end
    for (int k = 0; k < 4; k++) begin
      data_in_pulpino_turn = 2'(k + 1);
      @(negedge clk);
      if (k < 3) begin
        n_checks++;
        if (gpio_data_in !== eb[k+1] || data_in_io_turn !== 2'(k + 2)) begin
          n_fail++;
          $display("FAIL busy_byte%0d: got %h/%b want %h/%b", k + 1, gpio_data_in, data_in_io_turn, eb[k+1], 2'(k + 2));
        end
      end
    end
    n_checks++;
    if (data_in_done !== 1'b1 || gpio_data_in !== 8'hCA) begin
      n_fail++;
      $display("FAIL busy_done: got done=%b byte=%h want 1/CA", data_in_done, gpio_data_in);
    end
    gpio_data_out = 8'hAA; data_out_pulpino_turn = 2'b10;
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_out_io_turn !== 2'b00 || data_out_done !== 1'b1 || write_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL jump_ignored: got turn=%b done=%b word=%h want 00/1/12345678", data_out_io_turn, data_out_done, write_data);
    end
    data_out_pulpino_turn = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_concurrent();
    logic [7:0] hb [4] = '{8'hEF, 8'hCD, 8'hAB, 8'h89};
    logic [7:0] pb [4] = '{8'h0D, 8'hF0, 8'hAD, 8'h0B};
    read_data = 32'h89ABCDEF; do_read = 1'b1;
    gpio_data_out = pb[0]; data_out_pulpino_turn = 2'b01;
    @(negedge clk);
    do_read = 1'b0;
    n_checks++;
    if (gpio_data_in !== 8'hEF || data_in_io_turn !== 2'b01 || data_out_io_turn !== 2'b01 || data_out_done !== 1'b0) begin
      n_fail++;
      $display("FAIL conc_start: got %h/%b out_turn=%b odone=%b want EF/01/01/0", gpio_data_in, data_in_io_turn, data_out_io_turn, data_out_done);
    end
    for (int k = 1; k < 4; k++) begin
      data_in_pulpino_turn = 2'(k);
      gpio_data_out = pb[k]; data_out_pulpino_turn = 2'(k + 1);
      @(negedge clk);
      n_checks++;
      if (gpio_data_in !== hb[k] || data_in_io_turn !== 2'(k + 1) || data_out_io_turn !== 2'(k + 1)) begin
        n_fail++;
        $display("FAIL conc_step%0d: got %h/%b out_turn=%b want %h/%b/%b", k, gpio_data_in, data_in_io_turn, data_out_io_turn, hb[k], 2'(k + 1), 2'(k + 1));
      end
    end
    data_in_pulpino_turn = 2'b00;
    @(negedge clk);
    n_checks++;
    if (data_in_done !== 1'b1 || write_data !== 32'h0BADF00D || data_out_done !== 1'b1) begin
      n_fail++;
      $display("FAIL conc_done: got idone=%b word=%h odone=%b want 1/0BADF00D/1", data_in_done, write_data, data_out_done);
    end
  endtask

  task automatic test_abort();
    read_data = 32'h11223344; do_read = 1'b1;
    gpio_data_out = 8'h55; data_out_pulpino_turn = 2'b01;
    @(negedge clk);
    do_read = 1'b0;
    data_in_pulpino_turn = 2'b01;
    gpio_data_out = 8'h66; data_out_pulpino_turn = 2'b10;
    @(negedge clk);
    n_checks++;
    if (gpio_data_in !== 8'h33 || data_in_io_turn !== 2'b10 || data_out_io_turn !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_pre: got %h/%b out_turn=%b want 33/10/10", gpio_data_in, data_in_io_turn, data_out_io_turn);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gpio_data_in, data_in_io_turn, data_in_done, write_data, data_out_io_turn, data_out_done} !== 46'h0) begin
      n_fail++;
      $display("FAIL abort_reset: got %h/%b/%b word=%h %b/%b want all 0", gpio_data_in, data_in_io_turn, data_in_done, write_data, data_out_io_turn, data_out_done);
    end
    data_in_pulpino_turn = 2'b00; data_out_pulpino_turn = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (data_in_done !== 1'b0 || data_out_done !== 1'b0 || data_in_io_turn !== 2'b00 || write_data !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_after: got idone=%b odone=%b turn=%b word=%h want 0/0/00/0", data_in_done, data_out_done, data_in_io_turn, write_data);
    end
  endtask

  initial begin
    test_reset();
    test_host_send();
    test_pulpino_send();
    test_busy_illegal();
    test_concurrent();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulpino_gpio_link.md
Name: pulpino_gpio_link

Overview:
Registered bridge between a host-side 32-bit word interface (USB register file) and the PULPino GPIO bank.
- Host to PULPino: a 32-bit word is sent as 4 bytes over an 8-bit GPIO bus.
- PULPino to host: 4 bytes are collected from an 8-bit GPIO bus and assembled into one 32-bit word.
- Each direction uses a 2-bit mod-4 turn-token handshake.
- The block sits between the host register logic and PULPino gpio_in/gpio_out.

Parameters:
none (word width fixed at 32 bits, byte width at 8 bits, 4 bytes per word)

Ports:
clk  in  1  single system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
read_data  in  32  host word to send to PULPino
do_read  in  1  one-cycle start strobe for a host-to-PULPino transfer
gpio_data_in  out  8  byte presented to PULPino (drives gpio_in[7:0])
data_in_io_turn  out  2  token for the byte currently presented
data_in_pulpino_turn  in  2  PULPino ack token (from gpio_out)
data_in_done  out  1  host-to-PULPino word fully acknowledged
gpio_data_out  in  8  byte presented by PULPino
data_out_pulpino_turn  in  2  PULPino token for the byte on gpio_data_out
data_out_io_turn  out  2  bridge ack token for the last captured byte
write_data  out  32  assembled word from PULPino
data_out_done  out  1  write_data holds a newly completed word

Behaviour:
Reset:
- All outputs are 0.
- Both token counters are 00.
- Shadow registers are cleared.
- A reset asserted during a transfer aborts it immediately, with no partial completion.

Byte order is little-endian: byte k is bits [8k+7:8k].

Host-to-PULPino engine (states IDLE, SEND):
- IDLE + do_read: latch read_data into a shadow register, clear data_in_done, and go to SEND.
  - On the next cycle, gpio_data_in = byte0 and data_in_io_turn = 01.
- A byte k is presented with token (k+1) mod 4, so the tokens are 01, 10, 11, 00.
- SEND: when data_in_pulpino_turn == data_in_io_turn (the ack), present the next byte and increment the token.
  - Next byte and token are registered 1 cycle after the ack is sampled.
- Ack of byte3 (token 00): return to IDLE and set data_in_done = 1 on the next cycle.
  - data_in_done stays high until the next accepted do_read.
- gpio_data_in holds byte3 after completion.
- do_read while in SEND is ignored. read_data changes during SEND do not affect the word in flight.
- Pulpino tokens other than the current io token are ignored.

PULPino-to-host engine (byte index 0..3):
- A new byte is detected when data_out_pulpino_turn == data_out_io_turn + 1 (mod 4).
- On detection, capture gpio_data_out into byte slot [index], and set data_out_io_turn = data_out_pulpino_turn on the next cycle (this is the ack).
- Capture of byte0 clears data_out_done.
- After byte3 is captured, copy the assembled word to write_data and set data_out_done = 1 in the same registered update.
  - data_out_done stays high until the next byte0 capture.
- write_data changes only on word completion and never shows partial words.
- Token values equal to data_out_io_turn, or more than +1 ahead, produce no capture and no state change.

The two engines are fully independent. Simultaneous events in both directions are all serviced in the same cycle.

Optional Feature:
Macro: PULPINO_GPIO_SYNC_EN
- Defined:
  - data_in_pulpino_turn, data_out_pulpino_turn and gpio_data_out each pass through a 2-flop synchronizer before use.
  - The synchronizer flops reset to 0.
  - Handshake latency grows by 2 cycles per byte.
- Undefined: these inputs are used directly, with the latencies stated above.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with random inputs. Expect all outputs 0, tokens 00, data_in_done=0 and data_out_done=0.
2. Host send:
   - Pulse do_read with read_data=32'hDEADBEEF, then echo each token from PULPino 2 cycles after it appears.
   - Expect gpio_data_in sequence EF/01, BE/10, AD/11, DE/00.
   - Expect data_in_done=1 one cycle after the final ack.
3. PULPino send:
   - Drive gpio_data_out 78,56,34,12 with tokens 01,10,11,00, advancing each time data_out_io_turn matches.
   - Expect write_data=32'h12345678 and data_out_done=1 only after the 4th byte, with write_data unchanged before that.
4. Busy/illegal tokens:
   - A second do_read with 32'h0 during SEND is ignored, and the original word completes.
   - A pulpino-out token jump 00 to 10 produces no capture.
5. Concurrency and abort:
   - Run both directions simultaneously and expect both words correct.
   - Separately, assert rst_n=0 after byte1 and expect an immediate return to reset values, with no done asserted.
